id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register that replaces the combinational control-zeroing mux.
- Registers the control bundle, register addresses and operand data from ID into EX.
- Detects load-use hazards internally and inserts 1..N bubbles, sized to data-memory latency.
- Honours downstream stall and branch flush, and counts hazard bubbles for performance tracking.

Parameters:
- CTRL_W, 12: width of the packed control bundle (RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, ALUOp, ...).
- DATA_W, 32: operand/immediate width.
- RF_AW, 5: register-file address width.
- LOAD_USE_BUBBLES, 1: bubbles per load-use hazard. Legal range is 1..4; an elaboration error is raised otherwise.
- CNT_W, 16: width of the bubble statistics counter.

Ports:
- clk, in, 1: rising-edge clock.
- rstn, in, 1: asynchronous active-low reset.
- id_valid, in, 1: ID holds a real instruction.
- id_ctrl, in, CTRL_W: decoded control bundle.
- id_mem_read, in, 1: ID instruction is a load.
- id_rs1 / id_rs2 / id_rd, in, RF_AW each: source and destination register addresses.
- id_rs1_used / id_rs2_used, in, 1 each: source register is actually read.
- id_rs1_data / id_rs2_data / id_imm, in, DATA_W each: operands.
- ex_flush, in, 1: branch or jump taken in EX; kill the ID instruction.
- ex_stall, in, 1: downstream stall; freeze EX.
- ex_valid, out, 1: EX holds a real instruction.
- ex_ctrl, out, CTRL_W: registered control bundle.
- ex_mem_read, out, 1: EX instruction is a load.
- ex_rd, out, RF_AW: destination register.
- ex_rs1_data / ex_rs2_data / ex_imm, out, DATA_W each: registered operands.
- id_stall, out, 1: combinational; hold PC and IF/ID.
- bubble_count, out, CNT_W: number of hazard bubbles inserted.

Behaviour:
- Reset (asynchronous, rstn=0):
  - ex_valid, ex_ctrl, ex_mem_read, ex_rd, all data outputs, and bubble_count go to 0.
  - state goes to RUN and remaining goes to 0.
  - Reset mid-bubble abandons the bubble sequence immediately.
- Bubble: ex_valid=0, ex_ctrl=0, ex_mem_read=0, ex_rd=0. Data outputs hold their previous values.
- Hazard (combinational): hz = state==RUN & id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Per-edge priority, highest first:
  1. ex_flush: load a bubble, state goes to RUN, remaining goes to 0. bubble_count is not incremented.
  2. ex_stall: hold all registers, state and remaining. No counting.
  3. state==BUBBLE: load a bubble, decrement remaining, bubble_count+1. When remaining==1, go to RUN.
  4. hz: load a bubble, bubble_count+1. If LOAD_USE_BUBBLES>1, go to BUBBLE with remaining=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
  5. Otherwise: load ID into EX. ex_valid=id_valid. When id_valid=0, load a bubble.
- Outputs:
  - id_stall = !ex_flush & (ex_stall | hz | state==BUBBLE).
  - Latency is 1 cycle from ID inputs to EX outputs.
- Counter: bubble_count saturates at all-ones and does not wrap.
- Edge cases:
  - rd==0 never hazards.
  - A load depending on a load hazards normally.
  - Flush and hazard in the same cycle: flush wins and id_stall=0.
  - Stall during BUBBLE freezes remaining; the sequence resumes when the stall releases.
- State machine: two states, RUN and BUBBLE. remaining is a 2-bit down-counter.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {RUN, BUBBLE};
  - the CTRL_NOP constant (all zeros);
  - the bit-index constants of the ctrl bundle fields.
- One combinational sub-module, ld_use_detect, with inputs id_* addresses/used flags and ex_valid, ex_mem_read, ex_rd, and output hz. It is reused later for the MEM-stage check.
- Everything else stays in id_ex_stage_reg.

Test Plan:
1. Reset, then valid stream: release rstn and drive id_valid=1, id_ctrl=0x0A5, id_rd=3.
   - Next edge gives ex_valid=1, ex_ctrl=0x0A5, ex_rd=3.
   - id_stall=0 throughout.
   - Assert rstn=0 mid-cycle: all outputs read 0 before the next edge.
2. Load-use, LOAD_USE_BUBBLES=1: EX holds a load with rd=5; ID drives rs1=5, rs1_used=1.
   - id_stall=1 for 1 cycle and EX receives 1 bubble.
   - The dependent instruction enters EX the following edge.
   - bubble_count=1.
3. Load-use, LOAD_USE_BUBBLES=3, same stimulus:
   - id_stall=1 for 3 cycles and 3 consecutive bubbles.
   - bubble_count=3.
   - Repeat with rd=0: no stall.
4. Stall inside bubble, BUBBLES=3: assert ex_stall for 2 cycles after the first bubble.
   - EX is frozen for those cycles.
   - The 2 remaining bubbles follow after release, for a total stall of 5 cycles.
   - bubble_count=3.
5. Flush priority: assert ex_flush in the hazard-detect cycle, and separately mid-BUBBLE.
   - EX gets a bubble and id_stall=0.
   - state returns to RUN and bubble_count is unchanged.
6. Saturation with CNT_W=2: trigger 5 hazards.
   - bubble_count sticks at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID/EX state encoding, NOP control word and
// control-bundle field positions.
package pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  localparam int unsigned CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

  // Bit positions of the decoded control bundle fields
  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_ALUSRC   = 5;
  localparam int unsigned CTRL_ALUOP_LO = 6;
  localparam int unsigned CTRL_ALUOP_HI = 7;

endpackage

// File: rtl/ld_use_detect.sv
// Load-use hazard detector: flags a consumer whose source register is the
// destination of a load currently held in the following stage.
module ld_use_detect #(
  parameter int unsigned RF_AW = 5
) (
  input  logic             id_valid,
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [RF_AW-1:0] ex_rd,
  output logic             hz
);

  logic w_ld_live;
  logic w_src_hit;

  assign w_ld_live = id_valid & ex_valid & ex_mem_read & (ex_rd != '0);
  assign w_src_hit = (id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd));
  assign hz        = w_ld_live & w_src_hit;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with built-in load-use bubble insertion sized to
// data-memory latency, stall/flush handling and a saturating bubble counter.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W           = 12,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned RF_AW            = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic [RF_AW-1:0]  id_rs1,
  input  logic [RF_AW-1:0]  id_rs2,
  input  logic [RF_AW-1:0]  id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic [RF_AW-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 4) begin : g_bad_bubbles
    $error("id_ex_stage_reg: LOAD_USE_BUBBLES must be in 1..4");
  end
  if (CTRL_W > CTRL_MAX_W) begin : g_bad_ctrl_w
    $error("id_ex_stage_reg: CTRL_W exceeds CTRL_MAX_W");
  end

  localparam logic [1:0] REM_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_e     r_state;
  logic [1:0] r_remaining;
  logic       w_hz_raw;
  logic       w_hz;
  logic       w_in_bubble;
  logic       w_advance;
  logic       w_bubble;
  logic       w_load;
  logic       w_count;

  ld_use_detect #(.RF_AW(RF_AW)) u_ld_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hz          (w_hz_raw)
  );

  // Edge action decode, in priority order: flush, stall, bubble run, hazard, load
  assign w_in_bubble = (r_state == BUBBLE);
  assign w_hz        = (r_state == RUN) & w_hz_raw;
  assign w_advance   = ~ex_flush & ~ex_stall;
  assign w_count     = w_advance & (w_in_bubble | w_hz);
  assign w_load      = w_advance & ~w_in_bubble & ~w_hz & id_valid;
  assign w_bubble    = ex_flush | (w_advance & ~w_load);
  assign id_stall    = ~ex_flush & (ex_stall | w_hz | w_in_bubble);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RUN;
      r_remaining <= 2'd0;
    end else if (ex_flush) begin
      r_state     <= RUN;
      r_remaining <= 2'd0;
    end else if (ex_stall) begin
      r_state     <= r_state;
      r_remaining <= r_remaining;
    end else if (r_state == BUBBLE) begin
      r_remaining <= r_remaining - 2'd1;
      if (r_remaining == 2'd1) r_state <= RUN;
    end else if (w_hz && (LOAD_USE_BUBBLES > 1)) begin
      r_state     <= BUBBLE;
      r_remaining <= REM_INIT;
    end
  end

  // Bubbles clear the control path only; operand data keeps its last value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
    end else if (w_bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_W'(CTRL_NOP);
      ex_mem_read <= 1'b0;
      ex_rd       <= '0;
    end else if (w_load) begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= id_ctrl;
      ex_mem_read <= id_mem_read;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bubble_count <= '0;
    end else if (w_count && !(&bubble_count)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
